// File: rtl/mem_cmd_master.sv
// mem_cmd_master: byte-stream command parser driving the settings register file
// Ports: CLK/RESET_N clock and async active-low reset; RX_DATA/RX_VALID received bytes;
// TX_DATA/TX_VALID/TX_READY reply bytes; MEM_ADDR/MEM_WDATA/MEM_WE/MEM_RDATA register port;
// BUSY high outside IDLE; ERR one-cycle protocol error pulse.
module mem_cmd_master #(
  parameter int MEM_ADDR_WIDTH = 3,
  parameter int DATABusWidth   = 16,
  parameter int NUM_REGS       = 5,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [7:0]                RX_DATA,
  input  logic                      RX_VALID,
  output logic [7:0]                TX_DATA,
  output logic                      TX_VALID,
  input  logic                      TX_READY,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATABusWidth-1:0]   MEM_WDATA,
  output logic                      MEM_WE,
  input  logic [DATABusWidth-1:0]   MEM_RDATA,
  output logic                      BUSY,
  output logic                      ERR
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [3:0] {IDLE, GET_ADDR, GET_DHI, GET_DLO, WRITE, READ, SEND_ACK, SEND_HI, SEND_LO} state_t;
  state_t state;
  logic is_wr, addr_ok, nak, rx_ok, get_st, timeout;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [7:0] data_hi, send_byte;
  logic [DATABusWidth-1:0] shadow;
  logic [CW-1:0] cnt;
  // the whole address byte must be below NUM_REGS, so any upper bit set fails too
  assign rx_ok = ((RX_DATA >> MEM_ADDR_WIDTH) == 8'd0) && (RX_DATA < 8'(NUM_REGS));
  assign get_st = state == GET_ADDR || state == GET_DHI || state == GET_DLO;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign BUSY = state != IDLE;
  assign send_byte = state == SEND_HI ? shadow[15:8] : state == SEND_LO ? shadow[7:0] : nak ? 8'h15 : 8'h06;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      addr_ok   <= 1'b0;
      nak       <= 1'b0;
      addr      <= '0;
      data_hi   <= '0;
      shadow    <= '0;
      cnt       <= '0;
      TX_DATA   <= '0;
      TX_VALID  <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MEM_WE    <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      ERR    <= 1'b0;
      MEM_WE <= 1'b0;
      if (get_st && !RX_VALID) begin
        cnt <= timeout ? '0 : cnt + CW'(1);
        if (timeout) begin
          state <= IDLE;
          ERR   <= 1'b1;
        end
      end
      // bytes arriving while a transaction is executing or replying are dropped
      if (RX_VALID && state >= WRITE) ERR <= 1'b1;
      case (state)
        IDLE: if (RX_VALID) begin
          if (RX_DATA == 8'hA5 || RX_DATA == 8'h5A) begin
            is_wr <= RX_DATA == 8'hA5;
            cnt   <= '0;
            state <= GET_ADDR;
          end else ERR <= 1'b1;
        end
        GET_ADDR: if (RX_VALID) begin
          addr    <= RX_DATA[MEM_ADDR_WIDTH-1:0];
          addr_ok <= rx_ok;
          cnt     <= '0;
          if (is_wr) state <= GET_DHI;
          else if (rx_ok) begin
            MEM_ADDR <= RX_DATA[MEM_ADDR_WIDTH-1:0];
            state    <= READ;
          end else begin
            nak   <= 1'b1;
            state <= SEND_ACK;
          end
        end
        GET_DHI: if (RX_VALID) begin
          data_hi <= RX_DATA;
          cnt     <= '0;
          state   <= GET_DLO;
        end
        GET_DLO: if (RX_VALID) begin
          cnt <= '0;
          if (addr_ok) begin
            MEM_ADDR  <= addr;
            MEM_WDATA <= {data_hi, RX_DATA};
            MEM_WE    <= 1'b1;
            state     <= WRITE;
          end else begin
            nak   <= 1'b1;
            state <= SEND_ACK;
          end
        end
        WRITE: begin
          nak   <= 1'b0;
          state <= SEND_ACK;
        end
        READ: begin
          shadow <= MEM_RDATA;
          state  <= SEND_HI;
        end
        SEND_ACK, SEND_HI, SEND_LO: begin
          if (!TX_VALID) begin
            TX_VALID <= 1'b1;
            TX_DATA  <= send_byte;
          end else if (TX_READY) begin
            TX_VALID <= 1'b0;
            state    <= state == SEND_HI ? SEND_LO : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_cmd_master.md
Name: mem_cmd_master

Overview:
- Host-side initiator for the settings register file (delay, demod start, retransmit and settings words).
- Parses a byte stream from the serial receiver into register write and read transactions.
- Drives the register file's address, write-data and write-strobe port, and samples its read-data port.
- Returns acknowledge and read-data bytes to the serial transmitter over a valid/ready handshake.

Parameters:
- MEM_ADDR_WIDTH, 3, width of the register address; must match the register file.
- DATABusWidth, 16, register width; fixed at 16 because each word is split into two bytes.
- NUM_REGS, 5, number of implemented registers; addresses >= NUM_REGS are invalid.
- TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between bytes of one frame.

Ports:
- CLK  in  1  system clock; the register file is clocked on this same clock.
- RESET_N  in  1  asynchronous active-low reset.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe; RX_DATA is valid in that cycle.
- TX_DATA  out  8  byte to transmit.
- TX_VALID  out  1  TX_DATA is valid.
- TX_READY  in  1  transmitter accepts the byte.
- MEM_ADDR  out  MEM_ADDR_WIDTH  register address.
- MEM_WDATA  out  16  register write data.
- MEM_WE  out  1  one-cycle write strobe; the register file writes only when this is high.
- MEM_RDATA  in  16  combinational read data at MEM_ADDR.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (asynchronous, RESET_N low): state IDLE; all outputs 0; internal address, data and timeout registers cleared.
- Frame formats:
  - Write: 0xA5, ADDR, DATA[15:8], DATA[7:0].
  - Read: 0x5A, ADDR.
- ADDR byte handling: only ADDR[MEM_ADDR_WIDTH-1:0] is used. Any nonzero upper bit makes the address invalid, as does a value >= NUM_REGS.
- States: IDLE, GET_ADDR, GET_DHI, GET_DLO, WRITE, READ, SEND_ACK, SEND_HI, SEND_LO.
- IDLE:
  - RX byte 0xA5 or 0x5A: latch the direction, go to GET_ADDR.
  - Any other byte: pulse ERR, stay in IDLE.
- GET_ADDR:
  - On byte: latch the address.
  - Write frame: go to GET_DHI.
  - Read frame, valid address: go to READ.
  - Read frame, invalid address: go to SEND_ACK with NAK.
- GET_DHI: on byte, latch data[15:8], go to GET_DLO.
- GET_DLO:
  - On byte, latch data[7:0].
  - Valid address: go to WRITE.
  - Invalid address: go to SEND_ACK with NAK; no write occurs.
- WRITE:
  - MEM_WE=1 for exactly one cycle, with MEM_ADDR and MEM_WDATA stable.
  - This is the cycle after the last byte's RX_VALID.
  - Next state: SEND_ACK with ACK.
- READ:
  - MEM_ADDR is held stable; MEM_RDATA is captured into a shadow register at the end of this cycle.
  - Next state: SEND_HI.
- SEND_ACK: TX_DATA = 0x06 (ACK) or 0x15 (NAK).
- SEND_HI: TX_DATA = shadow[15:8].
- SEND_LO: TX_DATA = shadow[7:0].
- TX handshake rules:
  - TX_VALID is asserted the cycle after entering a send state.
  - TX_DATA is held stable while TX_VALID=1.
  - The byte completes on the first clock with TX_VALID and TX_READY both high; TX_VALID drops or the next byte is presented on the following cycle.
  - No timeout while waiting for TX_READY.
- After a send completes:
  - SEND_HI goes to SEND_LO.
  - SEND_ACK and SEND_LO go to IDLE.
- RX_VALID while in WRITE, READ or any SEND state: the byte is dropped and ERR pulses.
- Inter-byte timeout:
  - The counter runs in GET_ADDR, GET_DHI and GET_DLO, and is cleared on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse ERR, discard the partial frame, no write.
- MEM_ADDR and MEM_WDATA hold their last values in IDLE.
- MEM_WE is never high outside WRITE.
- Reset asserted mid-frame or mid-send: immediate return to IDLE; TX_VALID and MEM_WE drop asynchronously.

Test Plan:
- Bytes A5,02,12,34 with TX_READY=1 -> MEM_WE high for one cycle with MEM_ADDR=2, MEM_WDATA=0x1234, one cycle after the 0x34 strobe; then TX byte 0x06; BUSY back to 0.
- Bytes 5A,04 with MEM_RDATA=0x9F42 at address 4 -> TX bytes 0x9F then 0x42. Changing MEM_RDATA after the READ state does not alter either byte.
- Bytes A5,07,AA,BB -> no MEM_WE pulse; TX byte 0x15. Bytes 5A,05 -> TX byte 0x15 only.
- Byte 0x33 in IDLE -> ERR pulse, no state change. A5,01 then a gap of TIMEOUT_CYCLES (set to 16) -> ERR pulse, IDLE, no write.
- Read frame with TX_READY held low for 20 cycles -> TX_VALID and TX_DATA stable throughout; an RX byte arriving during that wait is dropped with an ERR pulse.
- RESET_N pulsed low after A5,03,12 -> no write; outputs 0; a subsequent full frame A5,03,00,01 writes 0x0001.
